alu_op_encoder: RTL
===================

// Module: alu_op_encoder
// PURPOSE
//  Encoding side of the ALU operation interface: accepts 32-bit RV32I instruction words over a
//  valid/ready handshake and produces the 4-bit ALU operation code, B-operand immediate,
//  operand-select and register indices consumed by the ALU and its register-file wrapper.
//  Sits between instruction fetch and the ALU in the datapath.
//  One registered stage plus a 1-entry skid buffer keep full throughput under back-pressure.
// PARAMETERS
//  DATA_WIDTH   32  instruction / immediate width
//  ILL_CNT_W     8  width of saturating illegal-instruction counter
// PORTS
//  clk              in   1   system clock, rising edge
//  reset            in   1   asynchronous, active-low reset
//  instr_valid_i    in   1   instr_i valid
//  instr_ready_o    out  1   encoder can accept an instruction this cycle
//  instr_i          in   32  RV32I instruction word
//  op_valid_o       out  1   output bundle valid
//  op_ready_i       in   1   downstream accepts bundle
//  alu_operation_o  out  4   ALU op code (ADDI 0000, SUB 0001, SRLI 0011, LUI 1000, ORI 1001, SLLI 1100)
//  alu_src_o        out  1   1: B operand = imm_o; 0: B operand = rs2 data
//  imm_o            out  32  B-operand immediate
//  rs1_o/rs2_o/rd_o out  5   register indices (instr[19:15], [24:20], [11:7])
//  reg_write_o      out  1   1 for every legal instruction; 0 when illegal
//  illegal_o        out  1   bundle carries an unsupported encoding
//  illegal_cnt_o    out  ILL_CNT_W  saturating count of illegal bundles delivered
// BEHAVIOUR
//  Reset (reset=0, async): op_valid_o=0, skid empty, instr_ready_o=0 while asserted, 1 the
//   first cycle after release; all bundle outputs 0; illegal_cnt_o=0.
//  Transfer occurs on an edge where valid&ready both high (either side).
//  Latency: instruction accepted at edge N appears on outputs after edge N (1 cycle).
//  Occupancy FSM: EMPTY (no bundle) -> FULL1 (output reg valid) -> FULL2 (output + skid).
//   EMPTY: accept -> FULL1.
//   FULL1: accept&~drain -> FULL2 (new bundle to skid); accept&drain -> FULL1 (replace);
//          ~accept&drain -> EMPTY.
//   FULL2: drain -> FULL1 (skid moves to output reg, same edge); no accept possible.
//  instr_ready_o is registered: 1 in EMPTY/FULL1, 0 in FULL2; never combinational from op_ready_i.
//  Outputs stable while op_valid_o=1 and op_ready_i=0 (no bundle changes, no drops).
//  Decode (opcode instr[6:0], funct3 [14:12], funct7 [31:25]):
//   0110111 LUI  -> 1000, alu_src=1, imm={{12{instr[31]}},instr[31:12]} (ALU shifts by 12)
//   0010011 f3=000 ADDI -> 0000, imm=sext(instr[31:20]); f3=110 ORI -> 1001, same imm
//   0010011 f3=001 f7=0 SLLI -> 1100; f3=101 f7=0 SRLI -> 0011; imm={27'b0,instr[24:20]}
//   0110011 f3=000 f7=0 ADD -> 0000, alu_src=0; f7=0100000 SUB -> 0001, alu_src=0; imm=0
//   anything else: illegal_o=1, alu_operation_o=0000, reg_write_o=0, imm=0, alu_src=0.
//  illegal_cnt_o increments on each drained bundle with illegal_o=1; saturates at all-ones.
//  Reset mid-operation: all buffered bundles discarded, counter cleared.
// CONFIGURATION
//  ALU_SHIFT_SUB_EN defined: SLLI, SRLI, SUB decoded as above.
//  Not defined: those three encodings flagged illegal; only LUI/ADDI/ORI/ADD legal;
//   op codes 1100/0011/0001 never emitted.
// STRUCTURE
//  alu_ctrl_pkg: opcode/funct3/funct7 constants, ALU op code localparams (shared with ALU),
//   bundle struct typedef, occupancy-state enum.
//  Sub-module alu_op_decode: purely combinational instr -> bundle; top holds FSM, output
//   register, skid register, counter.
// TESTING
//  Reset then 0x123450B7 (LUI x1) with op_ready_i=1 -> next cycle op=1000, imm=0x00012345, rd=1.
//  0xFFF00093 (ADDI x1,x0,-1) -> op=0000, imm=0xFFFFFFFF, alu_src=1, reg_write=1.
//  Stream ORI 0x0FF16113, SLLI 0x00311113, SUB 0x402081B3 with op_ready_i=0 for 3 cycles:
//   instr_ready_o falls after 2 accepts, outputs hold ORI (op=1001), then in-order 1100, 0001.
//  Without ALU_SHIFT_SUB_EN, SLLI 0x00311113 -> illegal_o=1, reg_write=0, illegal_cnt_o=1.
//  Drive 300 words 0x00000000 -> all illegal, illegal_cnt_o saturates at 255 (ILL_CNT_W=8).
//  Assert reset while FULL2 -> op_valid_o=0 immediately, no stale bundle after release.

Source files
------------

// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the ALU control path: RV32I opcode/funct fields,
// ALU operation codes (also used by the ALU itself), the decoded bundle
// carried from the encoder to the ALU, and the encoder occupancy states.
package alu_ctrl_pkg;

    localparam int XLEN = 32;

    // Major opcodes (instr[6:0])
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    // funct3 (instr[14:12])
    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;

    // funct7 (instr[31:25])
    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // ALU operation codes
    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_SRL = 4'b0011;
    localparam logic [3:0] ALU_LUI = 4'b1000;
    localparam logic [3:0] ALU_OR  = 4'b1001;
    localparam logic [3:0] ALU_SLL = 4'b1100;

    typedef struct packed {
        logic [3:0]      alu_operation;
        logic            alu_src;
        logic [XLEN-1:0] imm;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic            reg_write;
        logic            illegal;
    } alu_bundle_t;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_FULL1 = 2'd1,
        OCC_FULL2 = 2'd2
    } occ_state_e;

    // Sign-extend a 12-bit I-type immediate to XLEN.
    function automatic logic [XLEN-1:0] sext12(input logic [11:0] v);
        return {{(XLEN-12){v[11]}}, v};
    endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational RV32I instruction word -> ALU bundle decoder.
// Optional feature macro: ALU_SHIFT_SUB_EN (enables SLLI, SRLI and SUB;
// without it those encodings are reported as illegal).
module alu_op_decode
    import alu_ctrl_pkg::*;
(
    input  logic [XLEN-1:0] instr,
    output alu_bundle_t     bundle
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];

    // Decode one instruction; anything not recognised leaves the illegal defaults.
    always_comb begin
        bundle.alu_operation = ALU_ADD;
        bundle.alu_src       = 1'b0;
        bundle.imm           = '0;
        bundle.rs1           = instr[19:15];
        bundle.rs2           = instr[24:20];
        bundle.rd            = instr[11:7];
        bundle.reg_write     = 1'b0;
        bundle.illegal       = 1'b1;

        case (opcode)
            OPC_LUI: begin
                // Upper 20 bits passed right-aligned; the ALU applies the shift by 12.
                bundle.alu_operation = ALU_LUI;
                bundle.alu_src       = 1'b1;
                bundle.imm           = {{12{instr[31]}}, instr[31:12]};
                bundle.reg_write     = 1'b1;
                bundle.illegal       = 1'b0;
            end
            OPC_OP_IMM: begin
                if (funct3 == F3_ADD_SUB || funct3 == F3_OR) begin
                    bundle.alu_operation = (funct3 == F3_OR) ? ALU_OR : ALU_ADD;
                    bundle.alu_src       = 1'b1;
                    bundle.imm           = sext12(instr[31:20]);
                    bundle.reg_write     = 1'b1;
                    bundle.illegal       = 1'b0;
                end
`ifdef ALU_SHIFT_SUB_EN
                else if ((funct3 == F3_SLL || funct3 == F3_SRL_SRA) && funct7 == F7_BASE) begin
                    bundle.alu_operation = (funct3 == F3_SLL) ? ALU_SLL : ALU_SRL;
                    bundle.alu_src       = 1'b1;
                    bundle.imm           = {27'b0, instr[24:20]};
                    bundle.reg_write     = 1'b1;
                    bundle.illegal       = 1'b0;
                end
`endif
            end
            OPC_OP: begin
                if (funct3 == F3_ADD_SUB && funct7 == F7_BASE) begin
                    bundle.alu_operation = ALU_ADD;
                    bundle.reg_write     = 1'b1;
                    bundle.illegal       = 1'b0;
                end
`ifdef ALU_SHIFT_SUB_EN
                else if (funct3 == F3_ADD_SUB && funct7 == F7_ALT) begin
                    bundle.alu_operation = ALU_SUB;
                    bundle.reg_write     = 1'b1;
                    bundle.illegal       = 1'b0;
                end
`endif
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_op_encoder.sv
// ALU operation encoder: valid/ready instruction input, one registered output
// stage plus a one-entry skid buffer so throughput is kept under back-pressure.
// Optional feature macro: ALU_SHIFT_SUB_EN (see alu_op_decode).
//
//  state     | meaning
//  ----------+-----------------------------------------------
//  OCC_EMPTY | no bundle held, output invalid
//  OCC_FULL1 | output register holds a valid bundle
//  OCC_FULL2 | output register and skid buffer both hold bundles
module alu_op_encoder
    import alu_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ILL_CNT_W  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  instr_valid_i,
    output logic                  instr_ready_o,
    input  logic [DATA_WIDTH-1:0] instr_i,
    output logic                  op_valid_o,
    input  logic                  op_ready_i,
    output logic [3:0]            alu_operation_o,
    output logic                  alu_src_o,
    output logic [DATA_WIDTH-1:0] imm_o,
    output logic [4:0]            rs1_o,
    output logic [4:0]            rs2_o,
    output logic [4:0]            rd_o,
    output logic                  reg_write_o,
    output logic                  illegal_o,
    output logic [ILL_CNT_W-1:0]  illegal_cnt_o
);

    localparam logic [ILL_CNT_W-1:0] CNT_ONE = {{(ILL_CNT_W-1){1'b0}}, 1'b1};

    occ_state_e           state_q;
    occ_state_e           state_next;
    logic                 ready_q;
    logic                 ready_next;
    logic                 accept;
    logic                 drain;
    alu_bundle_t          dec_bundle;
    alu_bundle_t          out_q;
    alu_bundle_t          skid_q;
    logic [ILL_CNT_W-1:0] ill_cnt_q;

    alu_op_decode u_decode (
        .instr  (instr_i),
        .bundle (dec_bundle)
    );

    assign accept = instr_valid_i & ready_q;
    assign drain  = op_valid_o & op_ready_i;

    // Occupancy state and registered ready (ready is never a path from op_ready_i).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= OCC_EMPTY;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_next;
            ready_q <= ready_next;
        end
    end

    // Next occupancy from this cycle's accept/drain.
    always_comb begin
        state_next = state_q;
        case (state_q)
            OCC_EMPTY: if (accept) state_next = OCC_FULL1;
            OCC_FULL1: begin
                if (accept && !drain)      state_next = OCC_FULL2;
                else if (!accept && drain) state_next = OCC_EMPTY;
            end
            OCC_FULL2: if (drain) state_next = OCC_FULL1;
            default:   state_next = OCC_EMPTY;
        endcase
    end

    // FSM-derived outputs: valid from current state, ready staged for next cycle.
    always_comb begin
        op_valid_o = (state_q != OCC_EMPTY);
        ready_next = (state_next != OCC_FULL2);
    end

    // Output and skid registers; a full skid refills the output register on drain.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_q  <= '0;
            skid_q <= '0;
        end else begin
            case (state_q)
                OCC_EMPTY: if (accept) out_q <= dec_bundle;
                OCC_FULL1: begin
                    if (accept && !drain)     skid_q <= dec_bundle;
                    else if (accept && drain) out_q  <= dec_bundle;
                end
                OCC_FULL2: if (drain) out_q <= skid_q;
                default: ;
            endcase
        end
    end

    // Saturating count of illegal bundles handed downstream.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ill_cnt_q <= '0;
        end else if (drain && out_q.illegal && (ill_cnt_q != {ILL_CNT_W{1'b1}})) begin
            ill_cnt_q <= ill_cnt_q + CNT_ONE;
        end
    end

    assign instr_ready_o   = ready_q;
    assign alu_operation_o = out_q.alu_operation;
    assign alu_src_o       = out_q.alu_src;
    assign imm_o           = out_q.imm;
    assign rs1_o           = out_q.rs1;
    assign rs2_o           = out_q.rs2;
    assign rd_o            = out_q.rd;
    assign reg_write_o     = out_q.reg_write;
    assign illegal_o       = out_q.illegal;
    assign illegal_cnt_o   = ill_cnt_q;

endmodule
